// File: rtl/host_link_pkg.sv
// -----------------------------------------------------------------------------
// host_link_pkg
// Shared types and constants for the temperature-sensor host link.
//   - tx_state_e   : TX command FSM states. Each byte phase (CMD, LO, HI) has
//                    SEND / WAIT_HI / WAIT_LO sub-states.
//   - default command bytes and inter-byte timeout
//   - cmd_byte()   : selects the command byte for a threshold request
// -----------------------------------------------------------------------------
package host_link_pkg;

    localparam logic [7:0]  CMD_SET_HIGH_DEF   = 8'hA1;
    localparam logic [7:0]  CMD_SET_LOW_DEF    = 8'hA2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd300;

    typedef enum logic [3:0] {
        TX_IDLE        = 4'd0,
        TX_CMD_SEND    = 4'd1,
        TX_CMD_WAIT_HI = 4'd2,
        TX_CMD_WAIT_LO = 4'd3,
        TX_LO_SEND     = 4'd4,
        TX_LO_WAIT_HI  = 4'd5,
        TX_LO_WAIT_LO  = 4'd6,
        TX_HI_SEND     = 4'd7,
        TX_HI_WAIT_HI  = 4'd8,
        TX_HI_WAIT_LO  = 4'd9
    } tx_state_e;

    // sel = 0 selects the high-threshold command, sel = 1 the low one
    function automatic logic [7:0] cmd_byte(input logic       sel,
                                            input logic [7:0] cmd_high,
                                            input logic [7:0] cmd_low);
        logic [7:0] res;
        if (sel) begin
            res = cmd_low;
        end else begin
            res = cmd_high;
        end
        return res;
    endfunction

endpackage

// File: rtl/temp_sens_host_link_if.sv
// -----------------------------------------------------------------------------
// temp_sens_host_link_if
// Groups the controller-facing config handshake, the byte-UART TX/RX signals
// and the measurement outputs of the host link.
//   slave  : view of the host link itself
//   master : view of the surrounding system (controller + UART)
// -----------------------------------------------------------------------------
interface temp_sens_host_link_if;

    logic        cfg_valid;
    logic        cfg_sel;
    logic [15:0] cfg_value;
    logic        cfg_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        resync;
    logic [15:0] meas_value;
    logic        meas_valid;
    logic        frame_err;

    modport slave (
        input  cfg_valid, cfg_sel, cfg_value, tx_busy, rx_data, rx_ready, resync,
        output cfg_ready, tx_start, tx_data, meas_value, meas_valid, frame_err
    );

    modport master (
        output cfg_valid, cfg_sel, cfg_value, tx_busy, rx_data, rx_ready, resync,
        input  cfg_ready, tx_start, tx_data, meas_value, meas_valid, frame_err
    );

endinterface

// File: rtl/host_link_rx_asm.sv
// -----------------------------------------------------------------------------
// host_link_rx_asm
// Reassembles 2-byte measurement frames (low byte first) into a 16-bit word.
// Optional feature macro: HOST_LINK_TIMEOUT_EN (inter-byte timeout with
// frame_err pulse; without it frame_err is tied low and a half frame waits
// indefinitely for its high byte).
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   rx_data     : byte from UART, valid with rx_ready strobe
//   resync      : synchronous clear of the byte phase (beats rx_ready)
//   meas_value  : last complete measurement
//   meas_valid  : one-cycle pulse when meas_value updates
//   frame_err   : one-cycle pulse when a half frame is discarded by timeout
// -----------------------------------------------------------------------------
module host_link_rx_asm
`ifdef HOST_LINK_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd300
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        resync,
    output logic [15:0] meas_value,
    output logic        meas_valid,
    output logic        frame_err
);

    logic        phase_q, phase_d;   // 0 = expecting low byte
    logic [7:0]  lo_buf_q, lo_buf_d;
    logic [15:0] meas_value_q, meas_value_d;
    logic        meas_valid_q, meas_valid_d;

`ifdef HOST_LINK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_err_q, frame_err_d;
`endif

    // Next-state: resync first, then a received byte, then the timeout
    always_comb begin
        phase_d      = phase_q;
        lo_buf_d     = lo_buf_q;
        meas_value_d = meas_value_q;
        meas_valid_d = 1'b0;
`ifdef HOST_LINK_TIMEOUT_EN
        cnt_d        = cnt_q;
        frame_err_d  = 1'b0;
`endif
        if (resync) begin
            phase_d = 1'b0;
`ifdef HOST_LINK_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end else if (rx_ready) begin
`ifdef HOST_LINK_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (!phase_q) begin
                lo_buf_d = rx_data;
                phase_d  = 1'b1;
            end else begin
                meas_value_d = {rx_data, lo_buf_q};
                meas_valid_d = 1'b1;
                phase_d      = 1'b0;
            end
`ifdef HOST_LINK_TIMEOUT_EN
        end else if (phase_q) begin
            if (cnt_q == CNT_MAX) begin
                phase_d     = 1'b0;
                lo_buf_d    = 8'h00;
                frame_err_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
`else
        end else begin
            phase_d = phase_q;
        end
`endif
    end

    // RX state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 1'b0;
            lo_buf_q     <= 8'h00;
            meas_value_q <= 16'h0000;
            meas_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            lo_buf_q     <= lo_buf_d;
            meas_value_q <= meas_value_d;
            meas_valid_q <= meas_valid_d;
        end
    end

`ifdef HOST_LINK_TIMEOUT_EN
    // Timeout counter and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign meas_value = meas_value_q;
    assign meas_valid = meas_valid_q;

endmodule

// File: rtl/temp_sens_host_link.sv
// -----------------------------------------------------------------------------
// temp_sens_host_link
// Host-side end of the temperature-sensor UART link.
//   TX: on an accepted threshold request sends command byte, value[7:0],
//       value[15:8] to a byte UART, handshaking each byte on tx_busy.
//   RX: 2-byte measurement frame reassembly (host_link_rx_asm).
// Optional feature macro: HOST_LINK_TIMEOUT_EN (RX inter-byte timeout).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : temp_sens_host_link_if.slave -- cfg handshake (cfg_valid,
//                cfg_sel, cfg_value, cfg_ready), UART TX (tx_start, tx_data,
//                tx_busy), UART RX (rx_data, rx_ready, resync) and
//                measurement outputs (meas_value, meas_valid, frame_err)
// -----------------------------------------------------------------------------
module temp_sens_host_link
    import host_link_pkg::*;
#(
    parameter logic [7:0] CMD_SET_HIGH = CMD_SET_HIGH_DEF,
    parameter logic [7:0] CMD_SET_LOW  = CMD_SET_LOW_DEF
`ifdef HOST_LINK_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    temp_sens_host_link_if.slave  bus
);

    tx_state_e   state_q, state_d;
    logic        sel_q, sel_d;
    logic [15:0] value_q, value_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;

    // TX FSM next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        value_d    = value_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            TX_IDLE: begin
                // cfg_ready is high exactly in IDLE, so cfg_valid alone accepts
                if (bus.cfg_valid) begin
                    sel_d   = bus.cfg_sel;
                    value_d = bus.cfg_value;
                    state_d = TX_CMD_SEND;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_CMD_SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cmd_byte(sel_q, CMD_SET_HIGH, CMD_SET_LOW);
                    state_d    = TX_CMD_WAIT_HI;
                end else begin
                    state_d = TX_CMD_SEND;
                end
            end
            TX_CMD_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = TX_CMD_WAIT_LO;
                end else begin
                    state_d = TX_CMD_WAIT_HI;
                end
            end
            TX_CMD_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = TX_LO_SEND;
                end else begin
                    state_d = TX_CMD_WAIT_LO;
                end
            end
            TX_LO_SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = value_q[7:0];
                    state_d    = TX_LO_WAIT_HI;
                end else begin
                    state_d = TX_LO_SEND;
                end
            end
            TX_LO_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = TX_LO_WAIT_LO;
                end else begin
                    state_d = TX_LO_WAIT_HI;
                end
            end
            TX_LO_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = TX_HI_SEND;
                end else begin
                    state_d = TX_LO_WAIT_LO;
                end
            end
            TX_HI_SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = value_q[15:8];
                    state_d    = TX_HI_WAIT_HI;
                end else begin
                    state_d = TX_HI_SEND;
                end
            end
            TX_HI_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = TX_HI_WAIT_LO;
                end else begin
                    state_d = TX_HI_WAIT_HI;
                end
            end
            TX_HI_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_HI_WAIT_LO;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
        // registered so cfg_ready tracks the state it will be in next cycle
        cfg_ready_d = (state_d == TX_IDLE);
    end

    // TX FSM state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            sel_q       <= 1'b0;
            value_q     <= 16'h0000;
            cfg_ready_q <= 1'b1;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            value_q     <= value_d;
            cfg_ready_q <= cfg_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;

`ifdef HOST_LINK_TIMEOUT_EN
    host_link_rx_asm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_asm (
`else
    host_link_rx_asm u_rx_asm (
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (bus.rx_data),
        .rx_ready   (bus.rx_ready),
        .resync     (bus.resync),
        .meas_value (bus.meas_value),
        .meas_valid (bus.meas_valid),
        .frame_err  (bus.frame_err)
    );

endmodule

// File: tb/tb_temp_sens_host_link.sv
// -----------------------------------------------------------------------------
// tb_temp_sens_host_link
// Directed bench for temp_sens_host_link with a small byte-UART responder.
// Honours HOST_LINK_TIMEOUT_EN for the timeout scenario.
// -----------------------------------------------------------------------------
module tb_temp_sens_host_link;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    temp_sens_host_link_if bus();

    temp_sens_host_link dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // UART responder: busy rises the cycle after tx_start and lasts 4 cycles
    logic uart_busy;
    logic busy_force = 1'b0;
    int   busy_cnt;
    assign bus.tx_busy = uart_busy | busy_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_busy <= 1'b0;
            busy_cnt  <= 0;
        end else if (bus.tx_start) begin
            uart_busy <= 1'b1;
            busy_cnt  <= 4;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) uart_busy <= 1'b0;
        end
    end

    // Event log: transmitted bytes, pulse counters, protocol violations
    logic [7:0] tx_log [0:63];
    int nlog = 0;
    int start_viol = 0;
    int mv_cnt = 0;
    int fe_cnt = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.tx_start) begin
                tx_log[nlog % 64] <= bus.tx_data;
                nlog <= nlog + 1;
                if (bus.tx_busy) start_viol <= start_viol + 1;
            end
            if (bus.meas_valid) mv_cnt <= mv_cnt + 1;
            if (bus.frame_err)  fe_cnt <= fe_cnt + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic request(input logic sel, input logic [15:0] v);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = sel;
        bus.cfg_value = v;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.cfg_ready === 1'b1 && bus.tx_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic rs);
        @(negedge clk);
        bus.rx_data  = d;
        bus.rx_ready = 1'b1;
        bus.resync   = rs;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        bus.resync   = 1'b0;
    endtask

    task automatic test_reset;
        cyc(3);
        total++;
        if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin
            bad++; $display("FAIL reset_tx: tx_start=%b tx_data=%h want 0/00", bus.tx_start, bus.tx_data);
        end
        rst_n = 1'b1;
        cyc(2);
        total++;
        if (bus.cfg_ready !== 1'b1) begin
            bad++; $display("FAIL reset_cfg_ready: got %b want 1", bus.cfg_ready);
        end
        total++;
        if (bus.meas_value !== 16'h0000 || bus.meas_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_rx: meas=%h mv=%b fe=%b want 0000/0/0", bus.meas_value, bus.meas_valid, bus.frame_err);
        end
    endtask

    task automatic test_cmd_high;
        int base;
        bit ok;
        base = nlog;
        request(1'b0, 16'h1234);
        total++;
        if (bus.cfg_ready !== 1'b0) begin
            bad++; $display("FAIL cmd_high_ready_low: got %b want 0", bus.cfg_ready);
        end
        cyc(3);
        request(1'b1, 16'hFFFF);  // arrives while busy, must be dropped
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL cmd_high_done: timed out waiting for cfg_ready");
        end
        cyc(10);
        total++;
        if (nlog - base !== 3) begin
            bad++; $display("FAIL cmd_high_count: got %0d bytes want 3", nlog - base);
        end
        total++;
        if (tx_log[base] !== 8'hA1 || tx_log[base+1] !== 8'h34 || tx_log[base+2] !== 8'h12) begin
            bad++; $display("FAIL cmd_high_bytes: got %h %h %h want a1 34 12", tx_log[base], tx_log[base+1], tx_log[base+2]);
        end
    endtask

    task automatic test_busy_stall;
        int base;
        bit ok;
        base = nlog;
        busy_force = 1'b1;
        request(1'b1, 16'hBEEF);
        cyc(20);
        total++;
        if (nlog !== base || bus.cfg_ready !== 1'b0) begin
            bad++; $display("FAIL stall_hold: got %0d bytes ready=%b want 0 bytes ready=0", nlog - base, bus.cfg_ready);
        end
        busy_force = 1'b0;
        wait_idle(ok);
        cyc(2);
        total++;
        if (!ok || nlog - base !== 3) begin
            bad++; $display("FAIL stall_count: ok=%b got %0d bytes want 3", ok, nlog - base);
        end
        total++;
        if (tx_log[base] !== 8'hA2 || tx_log[base+1] !== 8'hEF || tx_log[base+2] !== 8'hBE) begin
            bad++; $display("FAIL stall_bytes: got %h %h %h want a2 ef be", tx_log[base], tx_log[base+1], tx_log[base+2]);
        end
        total++;
        if (start_viol !== 0) begin
            bad++; $display("FAIL start_while_busy: got %0d want 0", start_viol);
        end
    endtask

    task automatic test_rx_frame;
        int base;
        base = mv_cnt;
        rx_byte(8'hCD, 1'b0);
        total++;
        if (bus.meas_valid !== 1'b0) begin
            bad++; $display("FAIL rx_lo_no_valid: got %b want 0", bus.meas_valid);
        end
        rx_byte(8'hAB, 1'b0);
        total++;
        if (bus.meas_valid !== 1'b1 || bus.meas_value !== 16'hABCD) begin
            bad++; $display("FAIL rx_frame: valid=%b value=%h want 1/abcd", bus.meas_valid, bus.meas_value);
        end
        cyc(1);
        total++;
        if (bus.meas_valid !== 1'b0 || bus.meas_value !== 16'hABCD) begin
            bad++; $display("FAIL rx_hold: valid=%b value=%h want 0/abcd", bus.meas_valid, bus.meas_value);
        end
        cyc(2);
        total++;
        if (mv_cnt - base !== 1) begin
            bad++; $display("FAIL rx_pulses: got %0d want 1", mv_cnt - base);
        end
    endtask

    task automatic test_resync;
        int base;
        base = mv_cnt;
        rx_byte(8'h11, 1'b0);
        @(negedge clk); bus.resync = 1'b1;
        @(negedge clk); bus.resync = 1'b0;
        rx_byte(8'h22, 1'b0);
        rx_byte(8'h33, 1'b0);
        cyc(2);
        total++;
        if (bus.meas_value !== 16'h3322 || mv_cnt - base !== 1) begin
            bad++; $display("FAIL resync: value=%h pulses=%0d want 3322/1", bus.meas_value, mv_cnt - base);
        end
        // resync in the same cycle as rx_ready drops that byte
        base = mv_cnt;
        rx_byte(8'h44, 1'b1);
        rx_byte(8'h55, 1'b0);
        rx_byte(8'h66, 1'b0);
        cyc(2);
        total++;
        if (bus.meas_value !== 16'h6655 || mv_cnt - base !== 1) begin
            bad++; $display("FAIL resync_same_cycle: value=%h pulses=%0d want 6655/1", bus.meas_value, mv_cnt - base);
        end
    endtask

    task automatic test_timeout;
        int base;
        base = fe_cnt;
        rx_byte(8'h55, 1'b0);
`ifdef HOST_LINK_TIMEOUT_EN
        cyc(295);
        total++;
        if (fe_cnt !== base) begin
            bad++; $display("FAIL timeout_early: got %0d pulses want 0", fe_cnt - base);
        end
        cyc(10);
        total++;
        if (fe_cnt - base !== 1) begin
            bad++; $display("FAIL timeout_pulse: got %0d pulses want 1", fe_cnt - base);
        end
        rx_byte(8'h01, 1'b0);
        rx_byte(8'h02, 1'b0);
        total++;
        if (bus.meas_value !== 16'h0201 || bus.meas_valid !== 1'b1) begin
            bad++; $display("FAIL timeout_recover: value=%h valid=%b want 0201/1", bus.meas_value, bus.meas_valid);
        end
`else
        cyc(310);
        total++;
        if (fe_cnt !== base || bus.frame_err !== 1'b0) begin
            bad++; $display("FAIL no_timeout: got %0d pulses want 0", fe_cnt - base);
        end
        // the half frame is still pending, so the next byte completes it
        rx_byte(8'h01, 1'b0);
        total++;
        if (bus.meas_value !== 16'h0155 || bus.meas_valid !== 1'b1) begin
            bad++; $display("FAIL held_phase: value=%h valid=%b want 0155/1", bus.meas_value, bus.meas_valid);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int base;
        bit ok;
        bit seen;
        base = nlog;
        rx_byte(8'h77, 1'b0);  // half frame that must be lost
        request(1'b1, 16'h5A6B);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (nlog - base >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL mid_reach_lo: got %0d bytes want 2", nlog - base);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.cfg_ready !== 1'b1 || bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 ||
            bus.meas_value !== 16'h0000 || bus.meas_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_outputs: ready=%b start=%b data=%h meas=%h mv=%b want 1/0/00/0000/0",
                            bus.cfg_ready, bus.tx_start, bus.tx_data, bus.meas_value, bus.meas_valid);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        base = nlog;
        request(1'b1, 16'h0102);
        wait_idle(ok);
        cyc(2);
        total++;
        if (!ok || nlog - base !== 3 || tx_log[base] !== 8'hA2 || tx_log[base+1] !== 8'h02 || tx_log[base+2] !== 8'h01) begin
            bad++; $display("FAIL mid_after_reset: ok=%b n=%0d got %h %h %h want a2 02 01",
                            ok, nlog - base, tx_log[base], tx_log[base+1], tx_log[base+2]);
        end
        rx_byte(8'h88, 1'b0);
        rx_byte(8'h99, 1'b0);
        total++;
        if (bus.meas_value !== 16'h9988) begin
            bad++; $display("FAIL mid_rx_clean: got %h want 9988", bus.meas_value);
        end
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_sel   = 1'b0;
        bus.cfg_value = 16'h0000;
        bus.rx_data   = 8'h00;
        bus.rx_ready  = 1'b0;
        bus.resync    = 1'b0;
        test_reset();
        test_cmd_high();
        test_busy_stall();
        test_rx_frame();
        test_resync();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
